i2c_bus_frontend: RTL and testbench
===================================

I2C_BUS_FRONTEND -- requirements
Module: i2c_bus_frontend

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of metastability flops per line (legal: 2-4).
REQ-002 Parameter: FILTER_CYCLES, 3, consecutive stable sys_clk samples required before a filtered line changes (legal: 1-15).
REQ-003 Port: sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: scl_in  in  1  raw SCL pad input.
REQ-006 Port: sda_in  in  1  raw SDA pad input.
REQ-007 Port: scl_f / sda_f  out  1 each  synchronized, filtered line levels.
REQ-008 Port: scl_rise / scl_fall  out  1 each  one-cycle pulses on filtered SCL edges.
REQ-009 Port: start_det / rstart_det / stop_det  out  1 each  one-cycle pulses: START from idle, repeated START, STOP.
REQ-010 Port: bus_busy  out  1  high between START and STOP.
REQ-011 Port: bit_valid  out  1  one-cycle pulse per sampled bit; bit_data  out  1  sampled SDA.
REQ-012 Port: byte_valid  out  1  pulse on 8th bit; byte_data  out  8  assembled byte, MSB first.
REQ-013 Port: ack_valid  out  1  pulse on 9th bit; ack_bit  out  1  sampled SDA in ACK slot (0 = ACK).

Function
REQ-014 Each line SHALL pass through SYNC_STAGES flops, then the glitch filter (REQ-029), producing scl_f/sda_f.
REQ-015 Filter: filtered value SHALL update in the cycle the synchronized value has differed from it for FILTER_CYCLES consecutive cycles; any agreeing sample clears the run count.
REQ-016 Latency raw edge -> filtered edge SHALL be SYNC_STAGES+FILTER_CYCLES cycles; edge/event pulses SHALL assert the cycle after the filtered change.
REQ-017 START SHALL be sda_f 1->0 while scl_f stays 1; STOP SHALL be sda_f 0->1 while scl_f stays 1.
REQ-018 If scl_f and sda_f change in the same cycle, no START/STOP SHALL be reported.
REQ-019 FSM states BUS_IDLE, BUS_ACTIVE: IDLE->ACTIVE on START (start_det); ACTIVE->ACTIVE on START (rstart_det, not start_det); ACTIVE->IDLE on STOP; STOP in IDLE pulses stop_det, no state change.
REQ-020 bus_busy SHALL equal (state == BUS_ACTIVE).
REQ-021 In BUS_ACTIVE, each scl_rise SHALL pulse bit_valid with bit_data = sda_f and increment a 4-bit counter 0..8.
REQ-022 Rise with counter = 7 SHALL pulse byte_valid, byte_data = shift register incl. that bit; rise with counter = 8 SHALL pulse ack_valid/ack_bit instead of bit-to-byte shift, then counter wraps to 0.
REQ-023 START, rSTART and STOP SHALL clear the counter; scl_rise in BUS_IDLE SHALL produce no bit/byte/ack pulses.
REQ-024 byte_data and ack_bit SHALL hold their last value between pulses.

Reset
REQ-025 During sys_rst: all sync/filter flops, scl_f, sda_f = 1 (released bus); all pulses, bus_busy, ack_bit, byte_data, counter = 0; state BUS_IDLE.
REQ-026 Reset asserted mid-byte SHALL discard the partial byte; after release, no event SHALL be reported until a fresh START.

Configuration
REQ-027 Macro I2C_GLITCH_FILTER_EN: defined -> filter per REQ-015; undefined -> filter bypassed, FILTER_CYCLES ignored, latency = SYNC_STAGES.

Structure
REQ-028 Package i2c_pkg SHALL hold the bus-state encoding, counter width, and ACK/NACK level constants, shared with the slave FSM.
REQ-029 Sub-module i2c_glitch_filter (parameter FILTER_CYCLES, reset value 1) SHALL be instantiated once per line.

Verification
REQ-030 Idle bus, SDA falls with SCL high -> start_det once, bus_busy = 1, 2+3+1 cycles after raw edge (defaults).
REQ-031 Send 0xA5 + ACK low -> 8 bit_valid, byte_valid with byte_data = 0xA5, ack_valid with ack_bit = 0.
REQ-032 SDA low glitch of 2 cycles while SCL high and bus active -> no start/stop, sda_f unchanged; 3-cycle glitch -> rstart_det.
REQ-033 Mid-byte (after 4 bits) repeated START, then 0x3C -> rstart_det, byte_data = 0x3C (no residue).
REQ-034 SCL and SDA raw edges coincident -> no start_det/stop_det.
REQ-035 sys_rst pulsed after 5 bits -> all outputs at reset values, next bits ignored until START; without I2C_GLITCH_FILTER_EN, latency = 2 cycles and 1-cycle glitch propagates.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-state encoding, bit-counter width and
// ACK/NACK line levels used by the bus front end and the slave FSM.
package i2c_pkg;

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACTIVE = 1'b1
  } busState_e;

  // Bit counter spans 0..8: eight data bits plus the ACK slot
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(7);
  localparam logic [CNT_W-1:0] ACK_SLOT      = CNT_W'(8);

  // Open-drain levels: a released line reads high, which is also a NACK
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic ACK_LEVEL  = 1'b0;
  localparam logic NACK_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_bus_frontend_if.sv
// Pad inputs and decoded bus events of the I2C front end.
// master: the front end itself; slave: the consumer of its events.
interface i2c_bus_frontend_if;
  logic       scl_in;
  logic       sda_in;
  logic       scl_f;
  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       rstart_det;
  logic       stop_det;
  logic       bus_busy;
  logic       bit_valid;
  logic       bit_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ack_valid;
  logic       ack_bit;

  modport master (
    input  scl_in, sda_in,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det,
           bus_busy, bit_valid, bit_data, byte_valid, byte_data, ack_valid, ack_bit
  );

  modport slave (
    output scl_in, sda_in,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det,
           bus_busy, bit_valid, bit_data, byte_valid, byte_data, ack_valid, ack_bit
  );
endinterface

// File: rtl/i2c_glitch_filter.sv
// Per-line glitch filter: the output follows the input only after it has
// disagreed for FILTER_CYCLES consecutive samples. Built only when
// I2C_GLITCH_FILTER_EN is defined; otherwise the line passes straight through.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic lineIn,
  output logic lineOut
);

`ifdef I2C_GLITCH_FILTER_EN
  logic [3:0] runCnt;

  // Commit the new level on the FILTER_CYCLES-th disagreeing sample; any agreeing sample restarts the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lineOut <= LINE_IDLE;
      runCnt  <= '0;
    end else if (lineIn == lineOut) begin
      runCnt <= '0;
    end else if (runCnt == 4'(FILTER_CYCLES - 1)) begin
      lineOut <= lineIn;
      runCnt  <= '0;
    end else begin
      runCnt <= runCnt + 4'd1;
    end
  end
`else
  // Bypass: clock, reset and threshold are intentionally left without effect
  logic [5:0] unusedCfg;
  assign unusedCfg = {clk, rst, 4'(FILTER_CYCLES)};
  assign lineOut   = lineIn;
`endif

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C bus front end: synchronises and filters SCL/SDA, detects START,
// repeated START and STOP, and deserialises bits, bytes and the ACK slot.
// Optional glitch filtering is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_bus_frontend
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input logic               sys_clk,
  input logic               sys_rst,
  i2c_bus_frontend_if.master bus
);

  logic [SYNC_STAGES-1:0] sclSync;
  logic [SYNC_STAGES-1:0] sdaSync;
  logic                   sclFilt;
  logic                   sdaFilt;
  logic                   sclPrev;
  logic                   sdaPrev;
  busState_e              state;
  logic [CNT_W-1:0]       bitCnt;
  logic [7:0]             shiftReg;

  // Metastability chains; reset to the released (high) bus level
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclSync <= '1;
      sdaSync <= '1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], bus.scl_in};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], bus.sda_in};
    end
  end

  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) sclFilter (
    .clk(sys_clk), .rst(sys_rst), .lineIn(sclSync[SYNC_STAGES-1]), .lineOut(sclFilt)
  );

  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) sdaFilter (
    .clk(sys_clk), .rst(sys_rst), .lineIn(sdaSync[SYNC_STAGES-1]), .lineOut(sdaFilt)
  );

  assign bus.scl_f    = sclFilt;
  assign bus.sda_f    = sdaFilt;
  assign bus.bus_busy = (state == BUS_ACTIVE);

  // START/STOP need SCL high in both the previous and current sample, so a
  // simultaneous SCL/SDA change never qualifies
  logic startEv;
  logic stopEv;
  logic riseEv;
  assign startEv = sclPrev & sclFilt & sdaPrev & ~sdaFilt;
  assign stopEv  = sclPrev & sclFilt & ~sdaPrev & sdaFilt;
  assign riseEv  = ~sclPrev & sclFilt;

  // Previous filtered levels and registered SCL edge pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclPrev      <= LINE_IDLE;
      sdaPrev      <= LINE_IDLE;
      bus.scl_rise <= 1'b0;
      bus.scl_fall <= 1'b0;
    end else begin
      sclPrev      <= sclFilt;
      sdaPrev      <= sdaFilt;
      bus.scl_rise <= riseEv;
      bus.scl_fall <= sclPrev & ~sclFilt;
    end
  end

  // Bus-state FSM with bit/byte/ACK deserialiser; all event outputs registered
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= BUS_IDLE;
      bitCnt         <= '0;
      shiftReg       <= '0;
      bus.start_det  <= 1'b0;
      bus.rstart_det <= 1'b0;
      bus.stop_det   <= 1'b0;
      bus.bit_valid  <= 1'b0;
      bus.bit_data   <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.byte_data  <= '0;
      bus.ack_valid  <= 1'b0;
      bus.ack_bit    <= ACK_LEVEL;
    end else begin
      bus.start_det  <= 1'b0;
      bus.rstart_det <= 1'b0;
      bus.stop_det   <= 1'b0;
      bus.bit_valid  <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.ack_valid  <= 1'b0;
      case (state)
        BUS_IDLE: begin
          if (startEv) begin
            state         <= BUS_ACTIVE;
            bus.start_det <= 1'b1;
            bitCnt        <= '0;
          end else if (stopEv) begin
            bus.stop_det <= 1'b1;
          end
        end
        BUS_ACTIVE: begin
          if (startEv) begin
            bus.rstart_det <= 1'b1;
            bitCnt         <= '0;
          end else if (stopEv) begin
            state        <= BUS_IDLE;
            bus.stop_det <= 1'b1;
            bitCnt       <= '0;
          end else if (riseEv) begin
            bus.bit_valid <= 1'b1;
            bus.bit_data  <= sdaFilt;
            if (bitCnt == ACK_SLOT) begin
              bus.ack_valid <= 1'b1;
              bus.ack_bit   <= sdaFilt;
              bitCnt        <= '0;
            end else begin
              shiftReg <= {shiftReg[6:0], sdaFilt};
              if (bitCnt == LAST_DATA_BIT) begin
                bus.byte_valid <= 1'b1;
                bus.byte_data  <= {shiftReg[6:0], sdaFilt};
              end
              bitCnt <= bitCnt + CNT_W'(1);
            end
          end
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Scoreboard bench for i2c_bus_frontend: expected bus events are queued as
// the raw lines are driven and retired as the front end reports them.
module tb_i2c_bus_frontend;
  import i2c_pkg::*;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int LAT = 2 + 3;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = 8;

  localparam int EV_NONE   = 0;
  localparam int EV_START  = 1;
  localparam int EV_RSTART = 2;
  localparam int EV_STOP   = 3;
  localparam int EV_BIT    = 4;
  localparam int EV_BYTE   = 5;
  localparam int EV_ACK    = 6;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evRec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  evRec_t sb[$];
  int nChecks = 0;
  int nPass = 0;
  int sclRiseCnt = 0;
  int sdaLowCnt = 0;

  i2c_bus_frontend_if bus ();

  i2c_bus_frontend #(.SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pushEv(input int kind, input logic [7:0] data);
    evRec_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic popCheck(input int kind, input logic [7:0] data, input string name);
    evRec_t e;
    if (sb.size() == 0) begin
      checkVal({"unexpected_", name}, kind, EV_NONE);
    end else begin
      e = sb.pop_front();
      checkVal({name, "_kind"}, kind, e.kind);
      checkVal({name, "_data"}, {24'd0, data}, {24'd0, e.data});
    end
  endtask

  // Retire reported events against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.scl_rise) sclRiseCnt++;
      if (!bus.sda_f) sdaLowCnt++;
      if (bus.start_det)  popCheck(EV_START,  8'h00, "start");
      if (bus.rstart_det) popCheck(EV_RSTART, 8'h00, "rstart");
      if (bus.stop_det)   popCheck(EV_STOP,   8'h00, "stop");
      if (bus.bit_valid)  popCheck(EV_BIT,    {7'd0, bus.bit_data}, "bit");
      if (bus.byte_valid) popCheck(EV_BYTE,   bus.byte_data, "byte");
      if (bus.ack_valid)  popCheck(EV_ACK,    {7'd0, bus.ack_bit}, "ack");
    end
  end

  task automatic drive(input logic c, input logic d);
    @(posedge clk);
    #1;
    bus.scl_in = c;
    bus.sda_in = d;
    repeat (HOLD) @(posedge clk);
  endtask

  task automatic driveBit(input logic b);
    drive(1'b0, b);
    drive(1'b1, b);
    drive(1'b0, b);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) begin
      pushEv(EV_BIT, {7'd0, d[i]});
      if (i == 0) pushEv(EV_BYTE, d);
      driveBit(d[i]);
    end
    pushEv(EV_BIT, {7'd0, a});
    pushEv(EV_ACK, {7'd0, a});
    driveBit(a);
  endtask

  task automatic sdaGlitch(input int n);
    @(posedge clk);
    #1 bus.sda_in = 1'b0;
    repeat (n) @(posedge clk);
    #1 bus.sda_in = 1'b1;
    repeat (HOLD) @(posedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_scl_f"}, bus.scl_f, 1);
    checkVal({tag, "_sda_f"}, bus.sda_f, 1);
    checkVal({tag, "_busy"}, bus.bus_busy, 0);
    checkVal({tag, "_byte_data"}, bus.byte_data, 0);
    checkVal({tag, "_ack_bit"}, bus.ack_bit, 0);
    checkVal({tag, "_pulses"},
             {bus.scl_rise, bus.scl_fall, bus.start_det, bus.rstart_det, bus.stop_det,
              bus.bit_valid, bus.byte_valid, bus.ack_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int riseBefore;
    int lowBefore;
    bit found;

    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("por");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (HOLD) @(posedge clk);

    // START from idle, latency from raw SDA edge
    pushEv(EV_START, 8'h00);
    @(posedge clk);
    #1 bus.sda_in = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.start_det) found = 1;
    end
    checkVal("start_latency", n, LAT + 1);
    checkVal("busy_after_start", bus.bus_busy, 1);
    repeat (HOLD) @(posedge clk);
    drive(1'b0, 1'b0);

    // 0xA5 with ACK
    riseBefore = sclRiseCnt;
    sendByte(8'hA5, ACK_LEVEL);
    checkVal("a5_scl_rises", sclRiseCnt - riseBefore, 9);
    checkVal("a5_byte_hold", bus.byte_data, 8'hA5);
    checkVal("a5_ack_hold", bus.ack_bit, 0);

    // SDA glitches with SCL high on an active bus
    drive(1'b0, 1'b1);
    pushEv(EV_BIT, 8'h01);
    drive(1'b1, 1'b1);
    lowBefore = sdaLowCnt;
`ifdef I2C_GLITCH_FILTER_EN
    sdaGlitch(2);
    checkVal("glitch2_sda_low_cycles", sdaLowCnt - lowBefore, 0);
    checkVal("glitch2_busy", bus.bus_busy, 1);
    pushEv(EV_RSTART, 8'h00);
    pushEv(EV_STOP, 8'h00);
    sdaGlitch(3);
`else
    pushEv(EV_RSTART, 8'h00);
    pushEv(EV_STOP, 8'h00);
    sdaGlitch(1);
    checkVal("glitch1_sda_low_cycles", sdaLowCnt - lowBefore, 1);
`endif
    checkVal("glitch_busy_after", bus.bus_busy, 0);

    // Repeated START after 4 bits, then 0x3C with NACK
    pushEv(EV_START, 8'h00);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    pushEv(EV_BIT, 8'h00); driveBit(1'b0);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    drive(1'b0, 1'b1);
    pushEv(EV_BIT, 8'h01);
    drive(1'b1, 1'b1);
    pushEv(EV_RSTART, 8'h00);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    sendByte(8'h3C, NACK_LEVEL);
    checkVal("3c_byte_hold", bus.byte_data, 8'h3C);
    checkVal("3c_ack_hold", bus.ack_bit, 1);

    // STOP, then coincident SCL/SDA edges on the idle bus
    drive(1'b0, 1'b0);
    pushEv(EV_BIT, 8'h00);
    drive(1'b1, 1'b0);
    pushEv(EV_STOP, 8'h00);
    drive(1'b1, 1'b1);
    checkVal("stop_busy", bus.bus_busy, 0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    checkVal("coincident_busy", bus.bus_busy, 0);

    // Reset after 5 bits discards the partial byte
    pushEv(EV_START, 8'h00);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    pushEv(EV_BIT, 8'h00); driveBit(1'b0);
    pushEv(EV_BIT, 8'h00); driveBit(1'b0);
    pushEv(EV_BIT, 8'h01); driveBit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkResetState("midbyte_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (HOLD) @(posedge clk);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    checkVal("post_rst_busy", bus.bus_busy, 0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    pushEv(EV_START, 8'h00);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    sendByte(8'h5A, ACK_LEVEL);
    checkVal("5a_byte_hold", bus.byte_data, 8'h5A);
    drive(1'b0, 1'b0);
    pushEv(EV_BIT, 8'h00);
    drive(1'b1, 1'b0);
    pushEv(EV_STOP, 8'h00);
    drive(1'b1, 1'b1);

    checkVal("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
